// File: rtl/load_store_unit.sv
// Data memory initiator: one load/store per transaction, lane steering and load extension.
// Build option LSU_MISALIGN_TRAP_EN: misaligned accesses return rsp_err instead of being realigned.
module load_store_unit #(
   parameter int unsigned DM_ADDRESS = 9,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned RD_LAT     = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [31:0]           req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic                  busy,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [DM_ADDRESS-1:0] mem_addr,
   output logic [2:0]            mem_funct3,
   output logic [DATA_W-1:0]     mem_wd,
   output logic [3:0]            mem_be,
   input  logic [DATA_W-1:0]     mem_rd
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   localparam logic [2:0] LAT = 3'(RD_LAT);

   state_t state;
   logic [2:0] cnt;
   logic we_q;
   logic [2:0] f3_q;
   logic [1:0] off_q;

   logic is_b, is_h, mis, trap, accept;
   logic [1:0] off;
   logic [3:0] be;
   logic [DATA_W-1:0] wd;
   logic [15:0] s;
   logic [DATA_W-1:0] ext;
   logic unused;

   assign is_b   = req_funct3[1:0] == 2'b00;
   assign is_h   = req_funct3[1:0] == 2'b01;
   assign accept = req_valid & req_ready;
   assign busy   = ~req_ready;

   // Non-trap builds realign by dropping the offending offset bits.
   always_comb begin
      mis = 1'b0;
      off = 2'b00;
      be  = 4'b1111;
      wd  = req_wdata;
      unique case (1'b1)
         is_b: begin
            off = req_addr[1:0];
            be  = 4'b0001 << off;
            wd  = {4{req_wdata[7:0]}};
         end
         is_h: begin
            mis = req_addr[0];
            off = {req_addr[1], 1'b0};
            be  = 4'b0011 << off;
            wd  = {2{req_wdata[15:0]}};
         end
         default: mis = |req_addr[1:0];
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap   = mis;
   assign unused = ^req_addr[31:DM_ADDRESS];
`else
   assign trap   = 1'b0;
   assign unused = ^{req_addr[31:DM_ADDRESS], mis};
`endif

   always_comb begin
      s   = 16'(mem_rd >> {off_q, 3'b000});
      ext = mem_rd;
      unique case (1'b1)
         f3_q[1:0] == 2'b00:
            ext = {{24{s[7] & ~f3_q[2]}}, s[7:0]};
         f3_q[1:0] == 2'b01:
            ext = {{16{s[15] & ~f3_q[2]}}, s[15:0]};
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         we_q       <= 1'b0;
         f3_q       <= '0;
         off_q      <= '0;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_funct3 <= '0;
         mem_wd     <= '0;
         mem_be     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  req_ready <= 1'b0;
                  we_q      <= req_we;
                  f3_q      <= req_funct3;
                  off_q     <= off;
                  if (trap) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else begin
                     state      <= ISSUE;
                     mem_read   <= ~req_we;
                     mem_write  <= req_we;
                     mem_addr   <= {req_addr[DM_ADDRESS-1:2], 2'b00};
                     mem_funct3 <= req_funct3;
                     mem_wd     <= wd;
                     mem_be     <= be;
                  end
               end
            end
            ISSUE: begin
               if (we_q) begin
                  state      <= RESP;
                  rsp_valid  <= 1'b1;
                  rsp_rdata  <= '0;
                  mem_write  <= 1'b0;
                  mem_addr   <= '0;
                  mem_funct3 <= '0;
                  mem_wd     <= '0;
                  mem_be     <= '0;
               end else begin
                  state <= WAIT;
                  cnt   <= 3'd1;
               end
            end
            WAIT: begin
               if (cnt == LAT) begin
                  state      <= RESP;
                  rsp_valid  <= 1'b1;
                  rsp_rdata  <= ext;
                  mem_read   <= 1'b0;
                  mem_addr   <= '0;
                  mem_funct3 <= '0;
                  mem_wd     <= '0;
                  mem_be     <= '0;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            RESP: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
